// File: rtl/coil_dwell_guard.sv
// Single-channel coil guard: forwards charge requests to the coil while bounding
// dwell time and enforcing a minimum off time, reporting sparks and overruns.
module coil_dwell_guard #(
  parameter int TW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          ena,
  input  logic          tick,
  input  logic          coil_req,
  input  logic [TW-1:0] max_dwell,
  input  logic [TW-1:0] min_off,
  input  logic          fault_clr,
  output logic          coil_drv,
  output logic          spark,
  output logic          dwell_fault,
  output logic          fault_sticky,
  output logic [TW-1:0] last_dwell,
  output logic [CW-1:0] spark_cnt
);

  // state   | meaning
  // IDLE    | coil off, waiting for an enabled request
  // CHARGE  | coil driven, dwell being timed
  // HOLDOFF | coil off after a spark, enforcing min_off
  // LOCKOUT | coil off after overrun or early request, wait for release
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHARGE  = 2'd1,
    S_HOLDOFF = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          drv_q, drv_d;
  logic          spark_q, spark_d;
  logic          fault_q, fault_d;
  logic          sticky_q, sticky_d;
  logic [TW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          timer_sat;
  logic          dwell_over;
  logic          off_done;
  logic          rel_ev;
  logic          ovr_ev;

  assign timer_sat  = &timer_q;
  assign dwell_over = (timer_q >= max_dwell);
  assign off_done   = (timer_q >= min_off);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ena && coil_req) state_d = S_CHARGE;
      end
      S_CHARGE: begin
        // a release in the same cycle as an overrun is still a normal spark
        if (!ena)           state_d = S_IDLE;
        else if (!coil_req) state_d = S_HOLDOFF;
        else if (dwell_over) state_d = S_LOCKOUT;
      end
      S_HOLDOFF: begin
        if (!ena)          state_d = S_IDLE;
        else if (off_done) state_d = coil_req ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (!coil_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rel_ev = (state_q == S_CHARGE) && (state_d == S_HOLDOFF);
    ovr_ev = (state_q == S_CHARGE) && (state_d == S_LOCKOUT);

    // timer restarts on every state entry and saturates at all-ones
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && !timer_sat) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    drv_d   = (state_d == S_CHARGE);
    spark_d = rel_ev;
    fault_d = ovr_ev;

    if (ovr_ev) begin
      sticky_d = 1'b1;
    end else if (fault_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

    last_d = rel_ev ? timer_q : last_q;
    cnt_d  = rel_ev ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timer_q  <= '0;
      drv_q    <= 1'b0;
      spark_q  <= 1'b0;
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
      last_q   <= '0;
      cnt_q    <= '0;
    end else begin
      timer_q  <= timer_d;
      drv_q    <= drv_d;
      spark_q  <= spark_d;
      fault_q  <= fault_d;
      sticky_q <= sticky_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign coil_drv     = drv_q;
  assign spark        = spark_q;
  assign dwell_fault  = fault_q;
  assign fault_sticky = sticky_q;
  assign last_dwell   = last_q;
  assign spark_cnt    = cnt_q;

endmodule

// File: tb/tb_coil_dwell_guard.sv
// Bench for coil_dwell_guard: spark/overrun events are predicted from the driven
// stimulus into a queue and matched against the pulses the guard emits.
module tb_coil_dwell_guard;

  localparam int TW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          ena;
  logic          tick;
  logic          coil_req;
  logic [TW-1:0] max_dwell;
  logic [TW-1:0] min_off;
  logic          fault_clr;
  logic          coil_drv;
  logic          spark;
  logic          dwell_fault;
  logic          fault_sticky;
  logic [TW-1:0] last_dwell;
  logic [CW-1:0] spark_cnt;

  typedef struct {
    bit is_fault;
    int dwell;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  phase    = 0;
  int  tick_div = 1;
  int  exp_last = 0;
  int  exp_cnt  = 0;
  int  drv;
  bit  ov;
  int  hi;

  always #5 clk = ~clk;

  coil_dwell_guard #(.TW(TW), .CW(CW)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .ena          (ena),
    .tick         (tick),
    .coil_req     (coil_req),
    .max_dwell    (max_dwell),
    .min_off      (min_off),
    .fault_clr    (fault_clr),
    .coil_drv     (coil_drv),
    .spark        (spark),
    .dwell_fault  (dwell_fault),
    .fault_sticky (fault_sticky),
    .last_dwell   (last_dwell),
    .spark_cnt    (spark_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (nrst === 1'b1 && (spark === 1'b1 || dwell_fault === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {30'd0, spark, dwell_fault}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("event_fault", dwell_fault, e.is_fault);
        check_eq("event_spark", spark, !e.is_fault);
        check_eq("event_last_dwell", last_dwell, e.dwell);
        check_eq("event_spark_cnt", spark_cnt, e.cnt);
        if (e.is_fault) check_eq("event_sticky", fault_sticky, 1);
      end
    end
  end

  task automatic step(output bit t);
    tick = (phase % tick_div == 0);
    phase++;
    @(posedge clk);
    #1;
    t = tick;
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(t);
  endtask

  // Holds coil_req for 'hold' edges, then releases; predicts the resulting event.
  task automatic pulse(input int hold, input bit clr_during, output int drv_hi, output bit ovr);
    bit  t;
    int  tm;
    ev_t e;
    tm = 0;
    ovr = 0;
    drv_hi = 0;
    coil_req = 1;
    step(t);
    if (coil_drv) drv_hi++;
    for (int k = 1; k < hold; k++) begin
      fault_clr = clr_during && !ovr;
      step(t);
      if (!ovr) begin
        if (tm >= int'(max_dwell)) begin
          ovr = 1;
          e.is_fault = 1;
          e.dwell = exp_last;
          e.cnt = exp_cnt;
          exp_q.push_back(e);
        end else if (t && tm < 65535) begin
          tm++;
        end
      end
      if (coil_drv) drv_hi++;
    end
    fault_clr = 0;
    coil_req = 0;
    step(t);
    if (!ovr) begin
      exp_last = tm;
      exp_cnt = (exp_cnt + 1) % 16;
      e.is_fault = 0;
      e.dwell = exp_last;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    nrst = 0; ena = 1; tick = 0; coil_req = 0; fault_clr = 0;
    max_dwell = 100; min_off = 10;
    #12;
    check_eq("rst_coil_drv", coil_drv, 0);
    check_eq("rst_spark", spark, 0);
    check_eq("rst_dwell_fault", dwell_fault, 0);
    check_eq("rst_sticky", fault_sticky, 0);
    check_eq("rst_last_dwell", last_dwell, 0);
    check_eq("rst_spark_cnt", spark_cnt, 0);
    @(negedge clk);
    nrst = 1;
    idle(2);

    // normal spark
    pulse(40, 0, drv, ov);
    check_eq("normal_drv_cycles", drv, 40);
    check_eq("normal_no_ovr", ov, 0);
    check_eq("normal_last_dwell", last_dwell, 39);
    check_eq("normal_spark_cnt", spark_cnt, 1);
    check_eq("normal_sticky", fault_sticky, 0);
    idle(15);

    // dwell overrun, then a fresh request charges normally
    max_dwell = 20;
    pulse(60, 0, drv, ov);
    check_eq("ovr_drv_cycles", drv, 21);
    check_eq("ovr_flag", ov, 1);
    check_eq("ovr_sticky", fault_sticky, 1);
    check_eq("ovr_spark_cnt", spark_cnt, 1);
    idle(3);
    max_dwell = 100;
    pulse(10, 0, drv, ov);
    check_eq("after_ovr_drv", drv, 10);
    idle(15);

    // request inside the off window is never honoured
    min_off = 30;
    pulse(20, 0, drv, ov);
    idle(4);
    coil_req = 1;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      idle(1);
      if (coil_drv) hi++;
    end
    check_eq("minoff_no_recharge", hi, 0);
    coil_req = 0;
    idle(2);
    pulse(15, 0, drv, ov);
    check_eq("minoff_recharge_drv", drv, 15);
    idle(40);
    min_off = 10;

    // tick gating
    tick_div = 4;
    max_dwell = 10;
    pulse(30, 0, drv, ov);
    check_eq("gated_no_ovr", ov, 0);
    check_eq("gated_drv", drv, 30);
    check_eq("gated_dwell_range", (last_dwell == 7 || last_dwell == 8), 1);
    idle(60);
    pulse(45, 0, drv, ov);
    check_eq("gated_ovr", ov, 1);
    idle(5);
    tick_div = 1;

    // max_dwell = 0: drive lasts exactly one cycle
    max_dwell = 0;
    pulse(5, 0, drv, ov);
    check_eq("zero_max_drv", drv, 1);
    check_eq("zero_max_ovr", ov, 1);
    idle(3);
    max_dwell = 100;

    // ena dropped mid-charge
    coil_req = 1;
    idle(5);
    check_eq("ena_pre_drv", coil_drv, 1);
    ena = 0;
    idle(1);
    check_eq("ena_drop_drv", coil_drv, 0);
    coil_req = 0;
    idle(1);
    ena = 1;
    idle(2);
    check_eq("ena_drop_cnt", spark_cnt, exp_cnt);

    // fault_clr alone clears; coincident with an overrun the set wins
    fault_clr = 1;
    idle(1);
    fault_clr = 0;
    check_eq("clr_sticky", fault_sticky, 0);
    max_dwell = 3;
    pulse(10, 1, drv, ov);
    check_eq("clr_ovr_drv", drv, 4);
    check_eq("clr_set_wins", fault_sticky, 1);
    idle(3);
    max_dwell = 100;

    // async reset mid-charge
    coil_req = 1;
    idle(5);
    check_eq("rst_mid_pre_drv", coil_drv, 1);
    #2;
    nrst = 0;
    #1;
    check_eq("rst_mid_drv", coil_drv, 0);
    check_eq("rst_mid_spark", spark, 0);
    check_eq("rst_mid_sticky", fault_sticky, 0);
    check_eq("rst_mid_cnt", spark_cnt, 0);
    check_eq("rst_mid_last", last_dwell, 0);
    coil_req = 0;
    exp_cnt = 0;
    exp_last = 0;
    @(negedge clk);
    nrst = 1;
    idle(2);

    // spark counter wrap with min_off = 0
    min_off = 0;
    for (int i = 0; i < 17; i++) begin
      pulse(3, 0, drv, ov);
      idle(3);
    end
    check_eq("wrap_spark_cnt", spark_cnt, 1);

    idle(3);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coil_dwell_guard.md
# coil_dwell_guard

Per-channel coil driver stage that sits between the ignition comparators (coil14/coil23 requests) and the output pins. It passes each charge request to the coil and enforces a maximum dwell time and a minimum off time, both counted in ticks. It reports every completed spark with its measured dwell and flags dwell overruns. The top level instantiates one guard per coil pair; the SPI register block supplies the limits.

## Interface
Parameters:
- TW, 16, width of the dwell/off timers and limit inputs.
- CW, 16, width of the spark counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- nrst  in  1  asynchronous active-low reset.
- ena  in  1  guard enable; low forces coil off.
- tick  in  1  one-cycle time-base strobe; timers advance only when high.
- coil_req  in  1  raw charge request from the comparator stage (level).
- max_dwell  in  TW  dwell limit in ticks.
- min_off  in  TW  minimum coil-off time in ticks after a spark.
- fault_clr  in  1  clears fault_sticky.
- coil_drv  out  1  registered coil drive.
- spark  out  1  one-cycle pulse on a normal coil release.
- dwell_fault  out  1  one-cycle pulse on a dwell overrun.
- fault_sticky  out  1  latched overrun flag.
- last_dwell  out  TW  dwell of the last normal spark, in ticks.
- spark_cnt  out  CW  count of normal sparks; wraps.

## Operation
- States: IDLE, CHARGE, HOLDOFF, LOCKOUT.
- Timer:
  - One TW-bit timer is cleared on every state entry.
  - It increments when tick=1 and saturates at all-ones.
- IDLE (coil_drv=0): go to CHARGE when ena & coil_req.
- CHARGE (coil_drv=1). Priority, highest first:
  - ~ena → IDLE. No spark, no fault.
  - ~coil_req → HOLDOFF. Pulse spark, last_dwell<=timer, spark_cnt<=spark_cnt+1.
  - timer>=max_dwell → LOCKOUT. Pulse dwell_fault, set fault_sticky.
  - A request release and an overrun in the same cycle count as a normal spark.
- HOLDOFF (coil_drv=0):
  - Stay while timer<min_off.
  - Then → IDLE if coil_req=0, else → LOCKOUT. A request arriving inside the off window is never honoured, even in truncated form.
  - ~ena → IDLE immediately.
- LOCKOUT (coil_drv=0): → IDLE when coil_req=0, regardless of ena.
- fault_sticky:
  - Cleared by fault_clr.
  - If set and clear occur in the same cycle, set wins.
- Boundary cases:
  - max_dwell=0 gives an overrun one cycle after CHARGE entry, so coil_drv is high for exactly 1 cycle.
  - min_off=0 makes HOLDOFF last exactly 1 cycle.
  - last_dwell reports the saturated value if the timer saturated.
- Limits are sampled live every cycle. A change during CHARGE/HOLDOFF takes effect on the next compare.

## Timing
- Reset (nrst low, async):
  - State IDLE, timer 0.
  - coil_drv, spark, dwell_fault, fault_sticky all 0; last_dwell 0; spark_cnt 0.
- Rise latency: coil_req high sampled at edge N → coil_drv=1 after edge N (1 cycle).
- Release latency: coil_req low sampled at edge M → coil_drv=0 after edge M.
  - spark is high for the cycle after edge M, coincident with coil_drv falling.
  - last_dwell and spark_cnt update at the same edge.
- Overrun:
  - The compare is against the registered timer.
  - coil_drv falls at the edge where the overrun is seen; dwell_fault is high for the following cycle.
- Reset asserted mid-CHARGE drops coil_drv asynchronously with no spark pulse.

## Test plan
- Normal spark:
  - Stimulus: tick every cycle, max_dwell=100, min_off=10; coil_req high 40 cycles, then low.
  - Required: coil_drv high 40 cycles, one spark pulse, last_dwell=39..40 (bench checks the exact RTL-defined value 39), spark_cnt=1, no fault.
- Dwell overrun:
  - Stimulus: max_dwell=20; hold coil_req high 60 cycles.
  - Required: coil_drv high ~21 cycles, then 0; one dwell_fault pulse; fault_sticky=1; spark_cnt unchanged.
  - Required: coil_drv stays 0 until coil_req is released and re-asserted.
- Min-off violation:
  - Stimulus: min_off=30; after a normal spark, re-raise coil_req 5 cycles later and hold 50 cycles.
  - Required: no recharge (LOCKOUT); after release and re-request, a normal charge occurs.
- Tick gating:
  - Stimulus: tick every 4th cycle, max_dwell=10, coil_req high 30 cycles.
  - Required: no fault; last_dwell=7 or 8 depending on phase (bench computes the exact value).
  - Stimulus: coil_req high 45 cycles with the same settings.
  - Required: overrun after 10 ticks.
- Control edges:
  - ena dropped mid-CHARGE → coil_drv 0 next cycle, no spark.
  - fault_clr coincident with a new overrun → fault_sticky stays 1.
  - nrst pulsed mid-CHARGE → all outputs 0 immediately.
- spark_cnt wrap (CW=4 build):
  - Stimulus: 17 normal sparks.
  - Required: spark_cnt=1.
